// File: rtl/fb_pkg.sv
// Shared types, constants and address helper for the framebuffer writer.
package fb_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    DRAW       = 2'd0,
    WAIT_VSYNC = 2'd1,
    CLEAR      = 2'd2
  } fb_state_t;

  // Linear address of pixel (x, y) in buffer buf_idx. The caller truncates to its address width.
  function automatic int unsigned fb_addr(input int unsigned x,
                                          input int unsigned y,
                                          input logic        buf_idx,
                                          input int unsigned h_res,
                                          input int unsigned v_res);
    int unsigned base;
    base = buf_idx ? (h_res * v_res) : 32'd0;
    return base + (y * h_res) + x;
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Sequencer for the clear pass: walks offsets 0..DEPTH-1, one per cycle, after a start pulse.
module fb_clear_engine #(
  parameter int unsigned DEPTH = 480000,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] addr,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          busy_q;
  logic [AW-1:0] addr_q;
  logic          done_q;

  // Offset counter; done pulses the cycle after the final offset is presented.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q <= 1'b1;
        addr_q <= '0;
      end else if (busy_q) begin
        if (addr_q == LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign addr = addr_q;
  assign done = done_q;

endmodule

// File: rtl/framebuffer_writer.sv
// Pixel-stream sink: clips, skips transparent pixels, writes the back buffer, swaps on vsync
// and optionally clears the new back buffer.
module framebuffer_writer
  import fb_pkg::*;
#(
  parameter int unsigned H_RES       = 800,
  parameter int unsigned V_RES       = 600,
  parameter int unsigned COLOR_W     = 8,
  parameter int unsigned COORD_W     = 11,
  parameter int unsigned NUM_BUFFERS = 2,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
  parameter int unsigned ADDR_W      = $clog2(NUM_BUFFERS * H_RES * V_RES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixel_x_in,
  input  logic [COORD_W-1:0] pixel_y_in,
  input  logic [COLOR_W-1:0] pixel_color_in,
  input  logic               pixel_valid_in,
  input  logic               frame_end_in,
  output logic               pixel_ready_out,
  input  logic               vsync_in,
  input  logic               clear_en,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [COLOR_W-1:0] mem_wr_data,
  output logic               front_buffer,
  output logic               frame_swapped,
  output logic [CNT_W-1:0]   written_count,
  output logic [CNT_W-1:0]   clipped_count
);

  localparam int unsigned PIXELS = H_RES * V_RES;
  localparam int unsigned CLR_AW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

  if (NUM_BUFFERS != 1 && NUM_BUFFERS != 2) begin : g_bad_num_buffers
    $error("framebuffer_writer: NUM_BUFFERS must be 1 or 2");
  end

  fb_state_t state_q, state_d;

  logic               front_q;
  logic               swapped_q;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [COLOR_W-1:0] wr_data_q;
  logic [CNT_W-1:0]   written_q;
  logic [CNT_W-1:0]   clipped_q;
  logic [COLOR_W-1:0] clear_color_q;

  logic              accept;
  logic              on_screen;
  logic              opaque;
  logic              back;
  logic              start_clear;
  logic              enter_draw;
  logic              swap_pulse;
  logic              toggle_front;
  logic              clr_busy;
  logic              clr_done;
  logic [CLR_AW-1:0] clr_addr;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] clr_wr_addr;

  fb_clear_engine #(
    .DEPTH (PIXELS),
    .AW    (CLR_AW)
  ) u_clear (
    .clk   (clk),
    .reset (reset),
    .start (start_clear),
    .busy  (clr_busy),
    .addr  (clr_addr),
    .done  (clr_done)
  );

  // Datapath decode for the incoming pixel and the clear address.
  always_comb begin
    accept      = pixel_valid_in && (state_q == DRAW);
    on_screen   = (32'(pixel_x_in) < H_RES) && (32'(pixel_y_in) < V_RES);
    opaque      = (pixel_color_in != TRANSPARENT);
    back        = (NUM_BUFFERS == 2) ? ~front_q : 1'b0;
    pix_addr    = ADDR_W'(fb_addr(32'(pixel_x_in), 32'(pixel_y_in), back, H_RES, V_RES));
    clr_wr_addr = ADDR_W'(fb_addr(32'(clr_addr), 32'd0, back, H_RES, V_RES));
  end

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    state_d      = state_q;
    start_clear  = 1'b0;
    enter_draw   = 1'b0;
    swap_pulse   = 1'b0;
    toggle_front = 1'b0;
    unique case (state_q)
      DRAW: begin
        if (frame_end_in) begin
          if (NUM_BUFFERS == 2) begin
            state_d = WAIT_VSYNC;
          end else begin
            swap_pulse = 1'b1;
            if (clear_en) begin
              state_d     = CLEAR;
              start_clear = 1'b1;
            end else begin
              enter_draw = 1'b1;
            end
          end
        end
      end
      WAIT_VSYNC: begin
        if (vsync_in) begin
          toggle_front = 1'b1;
          swap_pulse   = 1'b1;
          if (clear_en) begin
            state_d     = CLEAR;
            start_clear = 1'b1;
          end else begin
            state_d    = DRAW;
            enter_draw = 1'b1;
          end
        end
      end
      CLEAR: begin
        if (clr_done) begin
          state_d    = DRAW;
          enter_draw = 1'b1;
        end
      end
      default: begin
        state_d    = DRAW;
        enter_draw = 1'b1;
      end
    endcase
  end

  // State, buffer index, registered write port and frame counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= DRAW;
      front_q       <= 1'b0;
      swapped_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      written_q     <= '0;
      clipped_q     <= '0;
      clear_color_q <= '0;
    end else begin
      state_q   <= state_d;
      swapped_q <= swap_pulse;
      if (toggle_front) begin
        front_q <= ~front_q;
      end
      if (start_clear) begin
        clear_color_q <= clear_color;
      end

      wr_en_q <= 1'b0;
      if (accept && on_screen && opaque) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= pix_addr;
        wr_data_q <= pixel_color_in;
      end else if (state_q == CLEAR && clr_busy) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= clr_wr_addr;
        wr_data_q <= clear_color_q;
      end

      // A frame boundary into DRAW wins over the count of a pixel accepted on that edge.
      if (enter_draw) begin
        written_q <= '0;
        clipped_q <= '0;
      end else if (accept) begin
        if (!on_screen) begin
          if (clipped_q != '1) clipped_q <= clipped_q + 1'b1;
        end else if (opaque) begin
          if (written_q != '1) written_q <= written_q + 1'b1;
        end
      end
    end
  end

  assign pixel_ready_out = (state_q == DRAW);
  assign mem_wr_en       = wr_en_q;
  assign mem_wr_addr     = wr_addr_q;
  assign mem_wr_data     = wr_data_q;
  assign front_buffer    = front_q;
  assign frame_swapped   = swapped_q;
  assign written_count   = written_q;
  assign clipped_count   = clipped_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench: expected RAM writes are queued at stimulus time and retired by a monitor.
module tb_framebuffer_writer;

  localparam int unsigned H  = 8;
  localparam int unsigned V  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned XW = 11;
  localparam int unsigned AW = 6;
  localparam int unsigned AW1 = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [XW-1:0] pixel_x = '0;
  logic [XW-1:0] pixel_y = '0;
  logic [CW-1:0] pixel_color = '0;
  logic          pixel_valid = 1'b0;
  logic          frame_end = 1'b0;
  logic          vsync = 1'b0;
  logic          clear_en = 1'b0;
  logic [CW-1:0] clear_color = '0;

  logic          pixel_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [CW-1:0] mem_wr_data;
  logic          front_buffer;
  logic          frame_swapped;
  logic [15:0]   written_count;
  logic [15:0]   clipped_count;

  logic           pixel_valid1 = 1'b0;
  logic           frame_end1 = 1'b0;
  logic           pixel_ready1;
  logic           mem_wr_en1;
  logic [AW1-1:0] mem_wr_addr1;
  logic [CW-1:0]  mem_wr_data1;
  logic           front_buffer1;
  logic           frame_swapped1;
  logic [15:0]    written_count1;
  logic [15:0]    clipped_count1;

  int  n_checks = 0;
  int  n_errors = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  framebuffer_writer #(
    .H_RES       (H),
    .V_RES       (V),
    .COLOR_W     (CW),
    .COORD_W     (XW),
    .NUM_BUFFERS (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_x_in      (pixel_x),
    .pixel_y_in      (pixel_y),
    .pixel_color_in  (pixel_color),
    .pixel_valid_in  (pixel_valid),
    .frame_end_in    (frame_end),
    .pixel_ready_out (pixel_ready),
    .vsync_in        (vsync),
    .clear_en        (clear_en),
    .clear_color     (clear_color),
    .mem_wr_en       (mem_wr_en),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .front_buffer    (front_buffer),
    .frame_swapped   (frame_swapped),
    .written_count   (written_count),
    .clipped_count   (clipped_count)
  );

  framebuffer_writer #(
    .H_RES       (H),
    .V_RES       (V),
    .COLOR_W     (CW),
    .COORD_W     (XW),
    .NUM_BUFFERS (1)
  ) dut1 (
    .clk             (clk),
    .reset           (reset),
    .pixel_x_in      (pixel_x),
    .pixel_y_in      (pixel_y),
    .pixel_color_in  (pixel_color),
    .pixel_valid_in  (pixel_valid1),
    .frame_end_in    (frame_end1),
    .pixel_ready_out (pixel_ready1),
    .vsync_in        (vsync),
    .clear_en        (clear_en),
    .clear_color     (clear_color),
    .mem_wr_en       (mem_wr_en1),
    .mem_wr_addr     (mem_wr_addr1),
    .mem_wr_data     (mem_wr_data1),
    .front_buffer    (front_buffer1),
    .frame_swapped   (frame_swapped1),
    .written_count   (written_count1),
    .clipped_count   (clipped_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int unsigned addr, input logic [CW-1:0] data);
    wr_t w;
    w.addr = AW'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Drive one pixel for one cycle; expected write (if any) is queued by the caller.
  task automatic drive_pixel(input int unsigned x, input int unsigned y,
                             input logic [CW-1:0] c, input logic fe);
    pixel_x     = XW'(x);
    pixel_y     = XW'(y);
    pixel_color = c;
    pixel_valid = 1'b1;
    frame_end   = fe;
    tick();
    pixel_valid = 1'b0;
    frame_end   = 1'b0;
  endtask

  // Retire every RAM write of the double-buffered instance against the scoreboard.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_t e;
      check("wr_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wr_data), 32'(e.data));
      end
    end
  end

  initial begin
    int cycles;
    int n_swap;
    int nw;

    repeat (3) tick();
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_front", 32'(front_buffer), 32'd0);
    check("rst_swapped", 32'(frame_swapped), 32'd0);
    check("rst_written", 32'(written_count), 32'd0);
    check("rst_clipped", 32'(clipped_count), 32'd0);
    reset = 1'b1;
    tick();
    check("ready_after_rst", 32'(pixel_ready), 32'd1);

    // Back buffer is 1 (base 32): (3,2) -> 32 + 2*8 + 3.
    push_wr(32 + 19, 8'h5A);
    drive_pixel(3, 2, 8'h5A, 1'b0);
    check("written_1", 32'(written_count), 32'd1);

    drive_pixel(8, 0, 8'h11, 1'b0);
    drive_pixel(0, 4, 8'h22, 1'b0);
    drive_pixel(1, 1, 8'h00, 1'b0);
    tick();
    check("clipped_2", 32'(clipped_count), 32'd2);
    check("written_still_1", 32'(written_count), 32'd1);

    push_wr(32 + 31, 8'h0F);
    drive_pixel(7, 3, 8'h0F, 1'b1);
    check("ready_low_wait", 32'(pixel_ready), 32'd0);
    check("written_2", 32'(written_count), 32'd2);
    // Pixel offered while not ready must be dropped.
    drive_pixel(2, 2, 8'h99, 1'b0);
    repeat (4) tick();
    check("front_before_vsync", 32'(front_buffer), 32'd0);
    check("ready_still_low", 32'(pixel_ready), 32'd0);
    check("written_no_drop", 32'(written_count), 32'd2);

    // Swap to front=1 and clear the new back buffer (0) with 0xAA.
    clear_en    = 1'b1;
    clear_color = 8'hAA;
    for (int i = 0; i < 32; i++) push_wr(i, 8'hAA);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("front_after_swap", 32'(front_buffer), 32'd1);
    check("swap_pulse", 32'(frame_swapped), 32'd1);
    cycles = 0;
    n_swap = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cycles++;
      if (i == 0) clear_color = 8'h55;
      if (frame_swapped) n_swap++;
      if (pixel_ready) break;
    end
    check("clear_ready", 32'(pixel_ready), 32'd1);
    check("clear_cycles", 32'(cycles), 32'd33);
    check("swap_single", 32'(n_swap), 32'd0);
    check("clear_all_written", 32'(exp_q.size()), 32'd0);
    check("clear_wr_idle", 32'(mem_wr_en), 32'd0);
    check("written_zeroed", 32'(written_count), 32'd0);
    check("clipped_zeroed", 32'(clipped_count), 32'd0);

    // vsync in DRAW must not swap.
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("vsync_draw_front", 32'(front_buffer), 32'd1);
    check("vsync_draw_swap", 32'(frame_swapped), 32'd0);

    // Second frame into buffer 0, then a clear of buffer 1 interrupted by reset.
    push_wr(0, 8'h33);
    drive_pixel(0, 0, 8'h33, 1'b0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check("ready_low_wait2", 32'(pixel_ready), 32'd0);
    clear_color = 8'hCC;
    for (int i = 0; i < 10; i++) push_wr(32 + i, 8'hCC);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("front_swap2", 32'(front_buffer), 32'd0);
    nw = 0;
    for (int i = 0; i < 100 && nw < 10; i++) begin
      tick();
      if (mem_wr_en) nw++;
    end
    check("writes_before_rst", 32'(nw), 32'd10);
    reset = 1'b0;
    tick();
    check("rst_abort_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_abort_front", 32'(front_buffer), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("ready_after_abort", 32'(pixel_ready), 32'd1);
    check("abort_no_extra", 32'(exp_q.size()), 32'd0);

    // After reset front=0, back=1: (1,0) -> 32 + 1.
    clear_en = 1'b0;
    push_wr(33, 8'h77);
    drive_pixel(1, 0, 8'h77, 1'b0);
    tick();
    check("post_rst_all_written", 32'(exp_q.size()), 32'd0);

    // Single-buffered instance: frame end swaps immediately without vsync.
    pixel_x      = XW'(3);
    pixel_y      = XW'(2);
    pixel_color  = 8'h44;
    pixel_valid1 = 1'b1;
    frame_end1   = 1'b1;
    tick();
    pixel_valid1 = 1'b0;
    frame_end1   = 1'b0;
    check("nb1_wr_en", 32'(mem_wr_en1), 32'd1);
    check("nb1_wr_addr", 32'(mem_wr_addr1), 32'd19);
    check("nb1_wr_data", 32'(mem_wr_data1), 32'h44);
    check("nb1_swap", 32'(frame_swapped1), 32'd1);
    check("nb1_front", 32'(front_buffer1), 32'd0);
    check("nb1_ready", 32'(pixel_ready1), 32'd1);
    tick();
    check("nb1_swap_once", 32'(frame_swapped1), 32'd0);
    check("nb1_ready_hold", 32'(pixel_ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
